pin_lock_ctrl: RTL and testbench

- Sequencing controller for the PIN-lock datapath.
- Accepts keypad digits over a valid/ready handshake and collects a PIN_LEN-digit code.
- Compares the code against a programmable stored PIN, counts consecutive failures and enforces a timed lockout.
- Holds the unlock window for a bounded time and lets the owner reprogram the PIN while open. Sits between the keypad front end and the door-actuator/status logic.

---
 rtl/pin_lock_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pin_lock_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pin_lock_ctrl.sv
// PIN-lock sequencing controller: collects keypad digits, checks them against a
// programmable PIN, tracks failures and lockout. Optional macro: PIN_LOCK_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for the first digit of a code
// ENTRY   | collecting the remaining code digits
// CHECK   | one-cycle compare of entered code against stored PIN
// OPEN    | unlocked, unlock window timer running
// LOCKOUT | too many failures, timed refusal of all input
// PROG    | collecting a new PIN while the window is frozen
module pin_lock_ctrl #(
   parameter int PIN_LEN           = 4,
   parameter int DIGIT_W           = 4,
   parameter int MAX_FAILS         = 3,
   parameter int UNLOCK_CYC        = 500,
   parameter int LOCKOUT_CYC       = 1000,
   parameter logic [PIN_LEN*DIGIT_W-1:0] DEFAULT_PIN = 16'h1234,
   parameter int ENTRY_TIMEOUT_CYC = 200,
   localparam int FC_W             = $clog2(MAX_FAILS+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_digit,
   output logic               key_ready,
   input  logic               prog_en,
   input  logic               relock,
   output logic               unlocked,
   output logic               locked_out,
   output logic               err_pulse,
   output logic [FC_W-1:0]    fail_cnt,
   output logic [2:0]         state_o
);

   localparam int CODE_W  = PIN_LEN*DIGIT_W;
   localparam int CNT_W   = $clog2(PIN_LEN+1);
   localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX+1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4,
      S_PROG    = 3'd5
   } state_t;

   state_t              state_q;
   logic [CODE_W-1:0]   pin_q;
   logic [CODE_W-1:0]   shift_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [TMR_W-1:0]    tmr_q;
   logic [FC_W-1:0]     fail_q;

   logic                accept;
   logic                last_digit;
   logic                mismatch;
   logic                tmo_expire;
   logic [CODE_W-1:0]   shift_nxt;
   logic [FC_W-1:0]     fail_inc;

   assign key_ready  = (state_q == S_IDLE) || (state_q == S_ENTRY) || (state_q == S_PROG);
   // A digit offered together with relock is dropped.
   assign accept     = key_valid && key_ready && !relock;
   assign shift_nxt  = (shift_q << DIGIT_W) | CODE_W'(key_digit);
   assign last_digit = (cnt_q == CNT_W'(PIN_LEN-1));
   assign mismatch   = (shift_q != pin_q);
   assign fail_inc   = (fail_q == FC_W'(MAX_FAILS)) ? fail_q : fail_q + FC_W'(1);

`ifdef PIN_LOCK_TIMEOUT_EN
   localparam int TO_W = $clog2(ENTRY_TIMEOUT_CYC+1);
   logic [TO_W-1:0] tmo_q;
   logic            prog_start;

   assign prog_start = (state_q == S_OPEN) && prog_en && !relock && (tmr_q > TMR_W'(1));
   assign tmo_expire = ((state_q == S_ENTRY) || (state_q == S_PROG)) &&
                       (tmo_q <= TO_W'(1)) && !accept && !relock;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if (accept || prog_start) begin
         tmo_q <= TO_W'(ENTRY_TIMEOUT_CYC);
      end else if (((state_q == S_ENTRY) || (state_q == S_PROG)) && (tmo_q != '0)) begin
         tmo_q <= tmo_q - TO_W'(1);
      end
   end
`else
   // No inter-digit timeout in this build; the parameter is only referenced here.
   assign tmo_expire = (ENTRY_TIMEOUT_CYC < 0);
`endif

   assign err_pulse  = ((state_q == S_CHECK) && mismatch) || tmo_expire;
   assign unlocked   = (state_q == S_OPEN);
   assign locked_out = (state_q == S_LOCKOUT);
   assign fail_cnt   = fail_q;
   assign state_o    = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pin_q   <= DEFAULT_PIN;
         shift_q <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         fail_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  shift_q <= shift_nxt;
                  cnt_q   <= CNT_W'(1);
                  state_q <= (PIN_LEN == 1) ? S_CHECK : S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (relock || tmo_expire) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else if (accept) begin
                  shift_q <= shift_nxt;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (last_digit) state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               cnt_q <= '0;
               if (!mismatch) begin
                  fail_q  <= '0;
                  tmr_q   <= TMR_W'(UNLOCK_CYC);
                  state_q <= S_OPEN;
               end else begin
                  fail_q <= fail_inc;
                  if (fail_inc == FC_W'(MAX_FAILS)) begin
                     tmr_q   <= TMR_W'(LOCKOUT_CYC);
                     state_q <= S_LOCKOUT;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_OPEN: begin
               if (relock || (tmr_q <= TMR_W'(1))) begin
                  state_q <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
                  if (prog_en) begin
                     cnt_q   <= '0;
                     state_q <= S_PROG;
                  end
               end
            end
            S_PROG: begin
               if (relock || tmo_expire) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else if (accept) begin
                  shift_q <= shift_nxt;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (last_digit) begin
                     pin_q   <= shift_nxt;
                     cnt_q   <= '0;
                     tmr_q   <= TMR_W'(UNLOCK_CYC);
                     state_q <= S_OPEN;
                  end
               end
            end
            S_LOCKOUT: begin
               if (tmr_q <= TMR_W'(1)) begin
                  fail_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Scoreboard bench for pin_lock_ctrl: stimulus queues expected state transitions,
// a monitor pops one per observed state change and checks outputs and dwell time.
module tb_pin_lock_ctrl;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_ready;
   logic       prog_en;
   logic       relock;
   logic       unlocked;
   logic       locked_out;
   logic       err_pulse;
   logic [1:0] fail_cnt;
   logic [2:0] state_o;

   typedef struct {
      logic [2:0] st;
      logic [1:0] fc;
      logic       err;
      int         dwell;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   pin_lock_ctrl #(
      .UNLOCK_CYC(8),
      .LOCKOUT_CYC(16),
      .ENTRY_TIMEOUT_CYC(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_valid(key_valid),
      .key_digit(key_digit),
      .key_ready(key_ready),
      .prog_en(prog_en),
      .relock(relock),
      .unlocked(unlocked),
      .locked_out(locked_out),
      .err_pulse(err_pulse),
      .fail_cnt(fail_cnt),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input int st, input int fc, input int err, input int dwell);
      exp_t e;
      e.st = 3'(st); e.fc = 2'(fc); e.err = 1'(err); e.dwell = dwell;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic keys4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      key(a); key(b); key(c); key(d);
   endtask

   // Mismatching code that does not reach MAX_FAILS.
   task automatic code_fail(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d, input int fcb);
      push(1, fcb, 0, 0); push(2, fcb, 0, 3); push(0, fcb+1, 1, 1);
      keys4(a, b, c, d);
      idle(2);
   endtask

   // Matching code followed by the full unlock window.
   task automatic code_open(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d, input int fcb);
      push(1, fcb, 0, 0); push(2, fcb, 0, 3); push(3, 0, 0, 1); push(0, 0, 0, 8);
      keys4(a, b, c, d);
      idle(10);
   endtask

   // Monitor: one expected record per state change.
   initial begin : monitor
      logic [2:0] prev;
      int         dwell;
      logic       err_seen;
      exp_t       e;
      prev = 3'd7;
      dwell = 0;
      err_seen = 1'b0;
      wait (rst_n === 1'b1);
      forever begin
         @(negedge clk);
         if (state_o != prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_transition: got state %0d from %0d, expected no change (t=%0t)", state_o, prev, $time);
            end else begin
               e = exp_q.pop_front();
               chk("state_o", state_o, e.st);
               chk("fail_cnt", fail_cnt, e.fc);
               chk("unlocked", unlocked, (e.st == 3'd3));
               chk("locked_out", locked_out, (e.st == 3'd4));
               chk("key_ready", key_ready, (e.st == 3'd0 || e.st == 3'd1 || e.st == 3'd5));
               chk("err_pulse_prev_state", err_seen, e.err);
               if (e.dwell != 0) chk("dwell_prev_state", dwell, e.dwell);
            end
            prev = state_o;
            dwell = 0;
            err_seen = 1'b0;
         end
         dwell++;
         err_seen = err_seen | err_pulse;
      end
   end

   initial begin : watchdog
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got no end of stimulus, expected finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst_n = 1'b0;
      key_valid = 1'b0;
      key_digit = 4'd0;
      prog_en = 1'b0;
      relock = 1'b0;
      push(0, 0, 0, 0);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Default PIN unlock, window of 8 cycles.
      code_open(4'd1, 4'd2, 4'd3, 4'd4, 0);

      // Three mismatches -> lockout; relock and digits ignored while locked.
      code_fail(4'd1, 4'd2, 4'd3, 4'd5, 0);
      code_fail(4'd1, 4'd2, 4'd3, 4'd5, 1);
      push(1, 2, 0, 0); push(2, 2, 0, 3); push(4, 3, 1, 1); push(0, 0, 0, 16);
      keys4(4'd1, 4'd2, 4'd3, 4'd5);
      idle(2);
      relock = 1'b1; key_valid = 1'b1; key_digit = 4'd4;
      idle(3);
      relock = 1'b0; key_valid = 1'b0;
      idle(20);

      // Two failures then success clears the count.
      code_fail(4'd1, 4'd2, 4'd3, 4'd5, 0);
      code_fail(4'd1, 4'd2, 4'd3, 4'd5, 1);
      code_open(4'd1, 4'd2, 4'd3, 4'd4, 2);

      // Reprogram to 9876; window restarts at full length.
      push(1, 0, 0, 0); push(2, 0, 0, 3); push(3, 0, 0, 1); push(5, 0, 0, 2);
      keys4(4'd1, 4'd2, 4'd3, 4'd4);
      idle(2);
      prog_en = 1'b1;
      idle(1);
      prog_en = 1'b0;
      push(3, 0, 0, 4); push(0, 0, 0, 8);
      keys4(4'd9, 4'd8, 4'd7, 4'd6);
      idle(10);
      code_fail(4'd1, 4'd2, 4'd3, 4'd4, 0);

      // New PIN opens; relock with prog_en in OPEN goes straight to IDLE.
      push(1, 1, 0, 0); push(2, 1, 0, 3); push(3, 0, 0, 1); push(0, 0, 0, 1);
      keys4(4'd9, 4'd8, 4'd7, 4'd6);
      idle(1);
      relock = 1'b1; prog_en = 1'b1;
      idle(1);
      relock = 1'b0; prog_en = 1'b0;
      idle(2);
      code_open(4'd9, 4'd8, 4'd7, 4'd6, 0);

      // Digit with relock in IDLE is dropped: no transition expected.
      relock = 1'b1; key_valid = 1'b1; key_digit = 4'd9;
      idle(1);
      relock = 1'b0; key_valid = 1'b0;
      idle(2);

      // Mid-entry relock after two digits keeps fail_cnt and discards the entry.
      code_fail(4'd1, 4'd1, 4'd1, 4'd1, 0);
      push(1, 1, 0, 0); push(0, 1, 0, 2);
      key(4'd1); key(4'd2);
      relock = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
      idle(1);
      relock = 1'b0; key_valid = 1'b0;
      idle(2);
      code_open(4'd9, 4'd8, 4'd7, 4'd6, 1);

`ifdef PIN_LOCK_TIMEOUT_EN
      // One digit then silence: timeout abort after 5 cycles in ENTRY.
      push(1, 0, 0, 0); push(0, 0, 1, 5);
      key(4'd1);
      idle(8);
`endif

      idle(3);
      chk("expected_queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
